// File: rtl/dmem_arbiter.sv
// Two-CPU round-robin arbiter in front of a single-ported line memory.
// One access at a time walks IDLE -> ISSUE -> WAIT -> DONE, with a WAIT timeout.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cpu0_u_addr,
    input  logic        cpu0_u_re,
    input  logic        cpu0_u_we,
    input  logic [63:0] cpu0_d_line,
    input  logic [10:0] cpu1_u_addr,
    input  logic        cpu1_u_re,
    input  logic        cpu1_u_we,
    input  logic [63:0] cpu1_d_line,
    input  logic        dmem_rdy,
    input  logic [63:0] dmem_rd_data,
    output logic [10:0] dmem_addr,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [63:0] dmem_wdata,
    output logic [63:0] u_rd_data,
    output logic        cpu0_dmem_permission,
    output logic        cpu1_dmem_permission,
    output logic        cpu0_done,
    output logic        cpu1_done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // The WAIT cycle whose increment brings wait_cnt to TIMEOUT-1 is the last one.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 2);

    state_t      state_q, state_d;
    logic        owner_q;
    logic        op_we_q;
    logic        abort_q;
    logic        last_grant_q;
    logic [7:0]  wait_cnt_q;

    logic        req0, req1;
    logic        sel;
    logic        accept;
    logic        finish_ok;
    logic        finish_to;

    assign req0 = cpu0_u_re | cpu0_u_we;
    assign req1 = cpu1_u_re | cpu1_u_we;
    assign sel  = (req0 && req1) ? ~last_grant_q : req1;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_rdy && (req0 || req1)) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wait_cnt_q != 8'd0 && dmem_rdy) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    finish_to = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            op_we_q      <= 1'b0;
            abort_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 8'd0;
            dmem_addr    <= 11'd0;
            dmem_wdata   <= 64'd0;
            u_rd_data    <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q    <= sel;
                op_we_q    <= sel ? cpu1_u_we : cpu0_u_we;
                dmem_addr  <= sel ? cpu1_u_addr : cpu0_u_addr;
                dmem_wdata <= sel ? cpu1_d_line : cpu0_d_line;
                abort_q    <= 1'b0;
            end
            if (state_q == ISSUE)
                wait_cnt_q <= 8'd0;
            else if (state_q == WAIT && wait_cnt_q != 8'hFF)
                wait_cnt_q <= wait_cnt_q + 8'd1;
            if (finish_ok && !op_we_q)
                u_rd_data <= dmem_rd_data;
            if (finish_to)
                abort_q <= 1'b1;
            if (state_q == DONE)
                last_grant_q <= owner_q;
        end
    end

    // All 1-bit outputs decode registered state only.
    assign dmem_re              = (state_q == ISSUE) && !op_we_q;
    assign dmem_we              = (state_q == ISSUE) &&  op_we_q;
    assign cpu0_dmem_permission = (state_q != IDLE) && !owner_q;
    assign cpu1_dmem_permission = (state_q != IDLE) &&  owner_q;
    assign cpu0_done            = (state_q == DONE) && !owner_q;
    assign cpu1_done            = (state_q == DONE) &&  owner_q;
    assign err                  = (state_q == DONE) &&  abort_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-CPU expected queues filled at request time,
// popped on strobes and done pulses; a small d_mem model supplies rdy/data.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int          TIMEOUT = 8;
    localparam logic [63:0] GARBAGE = 64'hBADD_BADD_BADD_BADD;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [10:0] addr;
        logic [63:0] line;
    } stim_t;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [63:0] line;
        logic [63:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cpu_addr [2];
    logic        cpu_re   [2];
    logic        cpu_we   [2];
    logic [63:0] cpu_line [2];
    logic        dmem_rdy;
    logic [63:0] dmem_rd_data;
    logic [10:0] dmem_addr;
    logic        dmem_re, dmem_we;
    logic [63:0] dmem_wdata, u_rd_data;
    logic        cpu0_dmem_permission, cpu1_dmem_permission;
    logic        cpu0_done, cpu1_done, err;

    dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu0_u_addr(cpu_addr[0]), .cpu0_u_re(cpu_re[0]), .cpu0_u_we(cpu_we[0]), .cpu0_d_line(cpu_line[0]),
        .cpu1_u_addr(cpu_addr[1]), .cpu1_u_re(cpu_re[1]), .cpu1_u_we(cpu_we[1]), .cpu1_d_line(cpu_line[1]),
        .dmem_rdy(dmem_rdy), .dmem_rd_data(dmem_rd_data),
        .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .u_rd_data(u_rd_data),
        .cpu0_dmem_permission(cpu0_dmem_permission), .cpu1_dmem_permission(cpu1_dmem_permission),
        .cpu0_done(cpu0_done), .cpu1_done(cpu1_done), .err(err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    stim_t       stim [2][128];
    int          stim_wr [2];
    int          stim_rd [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          exp_grant[$];
    logic        active  [2];
    logic        granted [2];
    logic [63:0] last_rd;
    logic [10:0] held_addr;
    logic [63:0] held_wdata;
    int          strobe_cyc;
    int          done_cyc;
    logic        gap_chk;
    logic        mem_ready, mem_hang, mem_block;
    int          mem_cnt, mem_lat;
    logic [10:0] mem_addr_l;

    function automatic logic [63:0] pat(input logic [10:0] a);
        if (a == 11'h123) return 64'hDEAD_BEEF_0000_0001;
        return {a, 21'h1F0F0F, ~a, 21'h0A5A5};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor(input logic strobe, input logic [1:0] dn);
        int   who;
        exp_t e;
        check("perm_excl", 64'(cpu0_dmem_permission & cpu1_dmem_permission), 64'd0);
        if (strobe) begin
            who = cpu1_dmem_permission ? 1 : 0;
            check("strobe_one_op", 64'(dmem_re & dmem_we), 64'd0);
            check("strobe_perm", 64'(cpu0_dmem_permission | cpu1_dmem_permission), 64'd1);
            if (exp_grant.size() > 0) check("grant_order", 64'(who), 64'(exp_grant.pop_front()));
            if (gap_chk && done_cyc >= 0) check("idle_gap", 64'(cyc - done_cyc), 64'd2);
            if ((who == 0 ? q0.size() : q1.size()) == 0) begin
                check("strobe_unexpected", 64'd1, 64'd0);
            end else begin
                e = (who == 0) ? q0[0] : q1[0];
                check("strobe_op_we", 64'(dmem_we), 64'(e.we));
                check("strobe_addr", 64'(dmem_addr), 64'(e.addr));
                check("strobe_wdata", dmem_wdata, e.line);
                held_addr  = e.addr;
                held_wdata = e.line;
            end
            granted[who] = 1'b1;
            strobe_cyc   = cyc;
        end else begin
            check("addr_hold", 64'(dmem_addr), 64'(held_addr));
            check("wdata_hold", dmem_wdata, held_wdata);
        end
        if (dn != 2'b00) begin
            check("done_both", 64'(&dn), 64'd0);
            who = dn[1] ? 1 : 0;
            check("done_perm", 64'(who == 1 ? cpu1_dmem_permission : cpu0_dmem_permission), 64'd1);
            if ((who == 0 ? q0.size() : q1.size()) == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = (who == 0) ? q0.pop_front() : q1.pop_front();
                check("done_err", 64'(err), 64'(e.err));
                check("done_latency", 64'(cyc - strobe_cyc), 64'(e.lat));
                if (!e.we && !e.err) last_rd = e.rdata;
            end
            done_cyc = cyc;
        end else begin
            check("err_without_done", 64'(err), 64'd0);
        end
        check("rd_data", u_rd_data, last_rd);
    endtask

    task automatic step();
        logic       strobe;
        logic [1:0] dn;
        stim_t      s;
        exp_t       e;
        @(negedge clk);
        cyc++;
        strobe = dmem_re | dmem_we;
        dn     = {cpu1_done, cpu0_done};
        monitor(strobe, dn);
        // d_mem model: drops rdy on a strobe, raises it mem_lat cycles later
        if (strobe) begin
            mem_addr_l = dmem_addr;
            mem_cnt    = 0;
            if (mem_hang)          mem_ready = 1'b0;
            else if (mem_lat == 0) mem_ready = 1'b1;
            else begin mem_ready = 1'b0; mem_cnt = mem_lat; end
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) mem_ready = 1'b1;
        end
        if (dn != 2'b00) mem_ready = 1'b1;
        dmem_rdy     = mem_ready & ~mem_block;
        dmem_rd_data = mem_ready ? pat(mem_addr_l) : GARBAGE;
        for (int c = 0; c < 2; c++) begin
            if (active[c] && dn[c]) begin
                cpu_re[c]  = 1'b0;
                cpu_we[c]  = 1'b0;
                active[c]  = 1'b0;
                granted[c] = 1'b0;
            end else if (!active[c] && stim_rd[c] < stim_wr[c]) begin
                s = stim[c][stim_rd[c]];
                stim_rd[c]++;
                cpu_addr[c] = s.addr;
                cpu_line[c] = s.line;
                cpu_re[c]   = s.re;
                cpu_we[c]   = s.we;
                active[c]   = 1'b1;
                e.we    = s.we;
                e.addr  = s.addr;
                e.line  = s.line;
                e.rdata = pat(s.addr);
                e.err   = mem_hang;
                e.lat   = mem_hang ? 8'(TIMEOUT) : 8'((mem_lat + 1 > 3) ? mem_lat + 1 : 3);
                if (c == 0) q0.push_back(e); else q1.push_back(e);
            end else if (active[c] && granted[c]) begin
                cpu_addr[c] = 11'($urandom);
                cpu_line[c] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic post(input int c, input logic re, input logic we, input logic [10:0] a, input logic [63:0] l);
        stim[c][stim_wr[c]] = '{re: re, we: we, addr: a, line: l};
        stim_wr[c]++;
    endtask

    function automatic logic all_idle();
        return stim_rd[0] == stim_wr[0] && stim_rd[1] == stim_wr[1] && !active[0] && !active[1]
               && q0.size() == 0 && q1.size() == 0;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", 64'(all_idle()), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cpu_re[c]  = 1'b0;
            cpu_we[c]  = 1'b0;
            active[c]  = 1'b0;
            granted[c] = 1'b0;
            stim_rd[c] = stim_wr[c];
        end
        q0.delete();
        q1.delete();
        exp_grant.delete();
        mem_ready  = 1'b1;
        mem_cnt    = 0;
        mem_hang   = 1'b0;
        mem_block  = 1'b0;
        dmem_rdy   = 1'b1;
        last_rd    = 64'd0;
        held_addr  = 11'd0;
        held_wdata = 64'd0;
        done_cyc   = -1;
        step();
        check("rst_bits", 64'({dmem_re, dmem_we, cpu0_dmem_permission, cpu1_dmem_permission,
                               cpu0_done, cpu1_done, err}), 64'd0);
        check("rst_addr", 64'(dmem_addr), 64'd0);
        check("rst_wdata", dmem_wdata, 64'd0);
        check("rst_rdata", u_rd_data, 64'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cpu_addr[c] = 11'd0;
            cpu_line[c] = 64'd0;
            cpu_re[c]   = 1'b0;
            cpu_we[c]   = 1'b0;
            stim_wr[c]  = 0;
            stim_rd[c]  = 0;
        end
        dmem_rd_data = GARBAGE;
        mem_addr_l   = 11'd0;
        mem_lat      = 3;
        gap_chk      = 1'b0;
        strobe_cyc   = 0;
        do_reset();

        // lone CPU0 read of 0x123, memory answers three cycles after the strobe
        post(0, 1'b1, 1'b0, 11'h123, 64'h1111_2222_3333_4444);
        drain(50);

        // rdy never dropped: the first WAIT cycle must ignore it
        mem_lat = 0;
        post(1, 1'b1, 1'b0, 11'h050, 64'h0);
        drain(50);
        mem_lat = 1;
        post(0, 1'b0, 1'b1, 11'h051, 64'h0123_4567_89AB_CDEF);
        drain(50);
        mem_lat = 3;

        // simultaneous write/read from reset, then lone CPU0, then a tie CPU1 wins
        do_reset();
        gap_chk = 1'b1;
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        post(0, 1'b0, 1'b1, 11'h055, 64'hCAFE_F00D_1234_5678);
        post(1, 1'b1, 1'b0, 11'h2AA, 64'h0);
        drain(80);
        gap_chk = 1'b0;
        exp_grant.push_back(0);
        post(0, 1'b1, 1'b0, 11'h300, 64'h0);
        drain(50);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        post(0, 1'b1, 1'b0, 11'h301, 64'h0);
        post(1, 1'b0, 1'b1, 11'h302, 64'h5555_AAAA_5555_AAAA);
        drain(80);

        // ten back-to-back accesses alternate; odd CPU0 writes also assert re
        do_reset();
        gap_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            post(0, 1'b1, 1'(i % 2), 11'(12'h100 + i), {32'hA000_0000, 32'(i)});
            post(1, 1'b1, 1'b0, 11'(12'h200 + i), 64'h0);
        end
        for (int k = 0; k < 10; k++) exp_grant.push_back(k % 2);
        drain(400);
        check("grants_consumed", 64'(exp_grant.size()), 64'd0);
        gap_chk = 1'b0;

        // memory never answers: timeout with err, read data untouched
        mem_hang = 1'b1;
        post(0, 1'b1, 1'b0, 11'h124, 64'h0);
        drain(50);
        mem_hang = 1'b0;

        // reset in the second WAIT cycle, then a normal access
        mem_hang = 1'b1;
        post(1, 1'b1, 1'b0, 11'h3FF, 64'h0);
        n = 0;
        while (!granted[1] && n < 20) begin
            step();
            n++;
        end
        check("reset_test_strobe", 64'(granted[1]), 64'd1);
        step();
        step();
        do_reset();
        post(1, 1'b1, 1'b0, 11'h0AB, 64'h0);
        drain(50);

        // rdy low in IDLE holds off the grant; ISSUE follows one cycle after rdy
        mem_block = 1'b1;
        post(1, 1'b1, 1'b0, 11'h077, 64'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("blocked_no_grant", 64'(cpu1_dmem_permission), 64'd0);
        end
        mem_block = 1'b0;
        step();
        check("blocked_still_idle", 64'(cpu1_dmem_permission), 64'd0);
        step();
        check("issue_after_rdy", 64'({dmem_re, cpu1_dmem_permission}), 64'd3);
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT-state cycles before an access is aborted; legal range 4..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 cpu0_u_addr  input  11  CPU0 line address; cpu1_u_addr is identical for CPU1.
REQ-005 cpu0_u_re, cpu0_u_we  input  1 each  CPU0 read/write request, level, held until cpu0_done; same pair for CPU1.
REQ-006 cpu0_d_line  input  64  CPU0 write line; cpu1_d_line is identical for CPU1.
REQ-007 dmem_rdy  input  1  d_mem idle/complete indicator.
REQ-008 dmem_rd_data  input  64  d_mem read line.
REQ-009 dmem_addr  output  11  latched address to d_mem.
REQ-010 dmem_re, dmem_we  output  1 each  one-cycle access strobes to d_mem.
REQ-011 dmem_wdata  output  64  latched write line to d_mem.
REQ-012 u_rd_data  output  64  registered read line, common to both CPUs.
REQ-013 cpu0_dmem_permission, cpu1_dmem_permission  output  1 each  owner indicator.
REQ-014 cpu0_done, cpu1_done  output  1 each  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle timeout pulse.

Function
REQ-016 FSM states are IDLE, ISSUE, WAIT and DONE; the state register and all outputs are registered or decoded from registers only.
REQ-017 IDLE: when dmem_rdy=1 and any request is present, the arbiter selects the owner, latches its addr, line and op (we over re when both are set), and moves to ISSUE; otherwise it stays in IDLE.
REQ-018 Selection: a lone requester wins; when both request, the CPU not equal to last_grant wins (round-robin).
REQ-019 last_grant updates to the owner in DONE; the reset value is 1, so CPU0 wins the first tie.
REQ-020 ISSUE lasts exactly 1 cycle: dmem_re or dmem_we=1 (never both), with dmem_addr and dmem_wdata showing latched values; next state is WAIT and wait_cnt is cleared to 0.
REQ-021 WAIT: wait_cnt increments each cycle, and dmem_rdy is ignored while wait_cnt=0.
REQ-022 WAIT, normal exit: when wait_cnt>=1 and dmem_rdy=1, the arbiter captures dmem_rd_data into u_rd_data for reads only and moves to DONE.
REQ-023 WAIT, timeout exit: when wait_cnt reaches TIMEOUT-1 without dmem_rdy, the arbiter moves to DONE with an abort flag set, and u_rd_data is not updated.
REQ-024 DONE lasts 1 cycle: owner's doneX=1, err=abort flag; next state is IDLE.
REQ-025 cpuX_dmem_permission=1 for the owner throughout ISSUE, WAIT and DONE; both are 0 in IDLE and never 1 simultaneously.
REQ-026 Latency: request at edge N in IDLE with rdy=1 gives ISSUE in cycle N+1, WAIT from N+2, and done no earlier than N+4.
REQ-027 Requests raised during ISSUE, WAIT or DONE are held pending and not dropped; a non-owner request waits and is served next.
REQ-028 Requester contract: re/we deassert by the edge after done; a request that is still high in IDLE is treated as a new access.
REQ-029 Latched addr, line and op are frozen from the IDLE->ISSUE edge; changes on CPU inputs mid-access have no effect.
REQ-030 dmem_addr and dmem_wdata hold their last latched values outside ISSUE; dmem_re/we are 0 outside ISSUE.
REQ-031 wait_cnt is 8 bits and saturates; it is not compared outside WAIT.

Reset
REQ-032 When rst=1 at an edge: state=IDLE, last_grant=1, wait_cnt=0, dmem_addr=0, dmem_wdata=0, u_rd_data=0, and all 1-bit outputs=0.
REQ-033 Reset mid-access (ISSUE/WAIT/DONE) aborts the access with no done/err pulse; the next access begins only after rst=0 and IDLE selection.

Verification
REQ-034 CPU0 read addr 0x123 alone, d_mem completes 3 cycles after strobe with data 0xDEAD_BEEF_0000_0001 -> one dmem_re pulse with dmem_addr=0x123, then u_rd_data equals that data with cpu0_done=1 in the same cycle, and err=0.
REQ-035 CPU0 write and CPU1 read issued in the same cycle from reset -> CPU0 is served first (dmem_we, wdata=cpu0_d_line), then CPU1 with no idle gap beyond one IDLE cycle; on the next simultaneous pair, CPU1 wins.
REQ-036 Both CPUs continuously re-request for 10 accesses -> grants alternate 0,1,0,1,...; permissions are never both high.
REQ-037 dmem_rdy held 0 after strobe, TIMEOUT=8 -> DONE after 7 WAIT cycles with err=1 and owner done=1, and u_rd_data is unchanged.
REQ-038 rst=1 asserted in the second WAIT cycle -> the next cycle shows all outputs at reset values, no done pulse, and a subsequent request is served normally.
REQ-039 dmem_rdy=0 in IDLE with CPU1 requesting -> no grant until rdy=1, then ISSUE follows on the next cycle.
